memory_responder: RTL and testbench
===================================

# memory_responder

Synthesizable memory responder on the receiving end of the memory bus that the testbench driver writes and the monitor samples. It accepts write and read commands on Wr_En/Rd_En/Address/Data_in and returns read data on Data_out with a Valid_out qualifier after a fixed, parameterized latency. It is the DUT the class-based environment drives, and its pipeline is the reference timing that scoreboard models follow.

## Interface
- Data_Width, 32, data bus width in bits
- Addr_Width, 5, address bus width in bits
- Depth, 2**Addr_Width, number of implemented words; must satisfy 1 ≤ Depth ≤ 2**Addr_Width
- Rd_Latency, 1, rising edges from Rd_En sample to Valid_out assertion; legal range 1..4

Ports:
- CLK  input  1  sole clock; all state changes on the rising edge
- Rst_n  input  1  asynchronous, active-low reset
- Wr_En  input  1  write command, sampled on the rising edge of CLK
- Rd_En  input  1  read command, sampled on the rising edge of CLK
- Address  input  Addr_Width  word address for the command
- Data_in  input  Data_Width  write data
- Data_out  output  Data_width  read data; meaningful only while Valid_out = 1
- Valid_out  output  1  one-cycle pulse per accepted read

## Operation
- Storage: Depth × Data_Width register array.
- Write: Wr_En = 1 at an edge with Address < Depth → mem[Address] ← Data_in at that edge. Address ≥ Depth → write dropped and no state changes.
- Read: Rd_En = 1 at an edge → a read entry (data, valid) enters an Rd_Latency-deep shift pipeline.
  - Data is taken from the array at the sampling edge.
  - Address ≥ Depth returns all zeros and still produces Valid_out.
- Simultaneous Wr_En and Rd_En: both are executed. The read returns the pre-write contents (read-before-write), including when the addresses match.
- A write issued while a read is in flight never changes that read's returned data.
- Back-to-back reads are accepted every cycle with no stalls. Valid_out stays high for consecutive cycles when reads arrive consecutively.
- Data_out holds its last value while Valid_out = 0. The bench checks data only when Valid_out = 1.
- Rd_En = 0 and Wr_En = 0 → idle; no state change except pipeline advance.
- No Wr_En/Rd_En gating on X: the bench drives known values after reset.

## Timing
- Reset (Rst_n = 0, asynchronous): all array words = 0, pipeline cleared, Data_out = 0, Valid_out = 0, with no clock needed.
- Mid-operation reset: in-flight reads are discarded and Valid_out drops immediately.
- Release: the first command is sampled on the first rising edge with Rst_n = 1.
- Read latency: Rd_En sampled at edge N → Valid_out = 1 and Data_out valid in the cycle following edge N + Rd_Latency − 1.
  - Rd_Latency = 1 gives a registered output visible right after edge N.
  - Valid_out deasserts at the next edge unless another read is in the pipeline.
- Write latency: data written at edge N is readable by a read sampled at edge N + 1 or later.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The driver applies inputs 1 time unit after the edge and the monitor samples 1 time unit before it, so all inputs are stable across the edge.

## Test plan
1. Reset check: Rst_n = 0 for 3 cycles, then read addresses 0, 5, 31 → Valid_out pulses with Data_out = 0x00000000 each time. Also assert Valid_out = 0 and Data_out = 0 during reset.
2. Write then read: write 0xDEADBEEF to addr 3 and 0x12345678 to addr 31 → reads return the same values. With Rd_Latency = 1, Valid_out rises exactly one edge after Rd_En is sampled; repeat with Rd_Latency = 3 and confirm Valid_out rises three edges after Rd_En is sampled.
3. Collision: preload addr 7 = 0x11111111. Assert Wr_En and Rd_En together at addr 7 with Data_in = 0x22222222 → read returns 0x11111111; the next read of addr 7 returns 0x22222222.
4. Streaming: reads of addrs 0..7 on 8 consecutive cycles after filling mem[i] = i*0x10 → Valid_out high for 8 consecutive cycles with Data_out = 0x00, 0x10, …, 0x70 in order.
5. Out-of-range, with Depth = 20: write 0xAAAAAAAA to addr 25 → dropped; read addr 25 → Data_out = 0 with Valid_out = 1; addr 19 is unaffected.
6. Reset mid-read, with Rd_Latency = 3: issue a read, then pull Rst_n low one cycle later → Valid_out never asserts for that read; after release, a read of a previously written address returns 0.

Source files
------------

// File: rtl/memory_responder_if.sv
// Memory command/response bus between the driver side (master) and the responder (slave).
interface memory_responder_if #(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = 5
);
  logic                  Wr_En;
  logic                  Rd_En;
  logic [Addr_Width-1:0] Address;
  logic [Data_Width-1:0] Data_in;
  logic [Data_Width-1:0] Data_out;
  logic                  Valid_out;

  modport master (
    output Wr_En, Rd_En, Address, Data_in,
    input  Data_out, Valid_out
  );

  modport slave (
    input  Wr_En, Rd_En, Address, Data_in,
    output Data_out, Valid_out
  );
endinterface

// File: rtl/memory_responder.sv
// Register-array memory with read-before-write semantics and a fixed-latency
// read pipeline; reads outside the implemented depth return zero.
module memory_responder #(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = 5,
  parameter int unsigned Depth      = 2**Addr_Width,
  parameter int unsigned Rd_Latency = 1
) (
  input  logic                CLK,
  input  logic                Rst_n,
  memory_responder_if.slave   bus
);
  localparam int unsigned CmpW = Addr_Width + 1;

  logic [Data_Width-1:0] mem_q  [Depth];
  logic [Data_Width-1:0] mem_d  [Depth];
  logic [Rd_Latency-1:0] valid_q;
  logic [Rd_Latency-1:0] valid_d;
  logic [Data_Width-1:0] data_q [Rd_Latency];
  logic [Data_Width-1:0] data_d [Rd_Latency];

  logic                  in_range_c;
  logic [Data_Width-1:0] rd_data_c;

  // Widen the address by one bit so Depth == 2**Addr_Width compares correctly.
  assign in_range_c = {1'b0, bus.Address} < CmpW'(Depth);
  assign rd_data_c  = in_range_c ? mem_q[bus.Address] : '0;

  // Next-state: array write and pipeline shift; each stage holds when no entry arrives.
  always_comb begin
    mem_d   = mem_q;
    valid_d = '0;
    data_d  = data_q;

    if (bus.Wr_En && in_range_c) begin
      mem_d[bus.Address] = bus.Data_in;
    end

    valid_d[0] = bus.Rd_En;
    if (bus.Rd_En) begin
      data_d[0] = rd_data_c;
    end

    for (int i = 1; i < int'(Rd_Latency); i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      for (int i = 0; i < int'(Rd_Latency); i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Valid_out = valid_q[Rd_Latency-1];
  assign bus.Data_out  = data_q[Rd_Latency-1];
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one shared command stream drives a latency-1 full-depth
// responder (u_a) and a latency-3, depth-20 responder (u_b) in parallel.
module tb_memory_responder;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  addr  = '0;
  logic [31:0] din   = '0;

  int n_checks = 0;
  int n_fail   = 0;

  memory_responder_if #(.Data_Width(32), .Addr_Width(5)) if_a ();
  memory_responder_if #(.Data_Width(32), .Addr_Width(5)) if_b ();

  assign if_a.Wr_En   = wr_en;
  assign if_a.Rd_En   = rd_en;
  assign if_a.Address = addr;
  assign if_a.Data_in = din;
  assign if_b.Wr_En   = wr_en;
  assign if_b.Rd_En   = rd_en;
  assign if_b.Address = addr;
  assign if_b.Data_in = din;

  memory_responder #(.Data_Width(32), .Addr_Width(5), .Depth(32), .Rd_Latency(1)) u_a (
    .CLK(clk), .Rst_n(rst_n), .bus(if_a)
  );
  memory_responder #(.Data_Width(32), .Addr_Width(5), .Depth(20), .Rd_Latency(3)) u_b (
    .CLK(clk), .Rst_n(rst_n), .bus(if_b)
  );

  always #5 clk = ~clk;

  // Apply one command for exactly one rising edge; return 1 time unit after that edge.
  task automatic step(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; addr = a; din = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
    #1;
    n_checks++; if (if_a.Valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_a got %b want 0", if_a.Valid_out); end
    n_checks++; if (if_a.Data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data_a got %h want 0", if_a.Data_out); end
    n_checks++; if (if_b.Valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_b got %b want 0", if_b.Valid_out); end
    n_checks++; if (if_b.Data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data_b got %h want 0", if_b.Data_out); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (addrs[k]) begin
      step(1'b0, 1'b1, addrs[k], 32'h0);
      n_checks++; if (if_a.Valid_out !== 1'b1 || if_a.Data_out !== 32'h0) begin
        n_fail++; $display("FAIL rst_read_a[%0d] got v=%b d=%h want v=1 d=0", addrs[k], if_a.Valid_out, if_a.Data_out); end
      step(1'b0, 1'b0, 5'd0, 32'h0);
      step(1'b0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (if_b.Valid_out !== 1'b1 || if_b.Data_out !== 32'h0) begin
        n_fail++; $display("FAIL rst_read_b[%0d] got v=%b d=%h want v=1 d=0", addrs[k], if_b.Valid_out, if_b.Data_out); end
    end
  endtask

  task automatic test_write_read();
    logic [4:0]  ra [2];
    logic [31:0] ea [2];
    logic [31:0] eb [2];
    ra[0] = 5'd3;  ea[0] = 32'hDEADBEEF; eb[0] = 32'hDEADBEEF;
    ra[1] = 5'd31; ea[1] = 32'h12345678; eb[1] = 32'h0;
    step(1'b1, 1'b0, 5'd3,  32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd31, 32'h12345678);
    foreach (ra[k]) begin
      step(1'b0, 1'b1, ra[k], 32'h0);
      n_checks++; if (if_a.Valid_out !== 1'b1 || if_a.Data_out !== ea[k]) begin
        n_fail++; $display("FAIL wr_rd_a[%0d] got v=%b d=%h want v=1 d=%h", ra[k], if_a.Valid_out, if_a.Data_out, ea[k]); end
      n_checks++; if (if_b.Valid_out !== 1'b0) begin
        n_fail++; $display("FAIL lat3_early1[%0d] got v=%b want 0", ra[k], if_b.Valid_out); end
      step(1'b0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (if_a.Valid_out !== 1'b0 || if_a.Data_out !== ea[k]) begin
        n_fail++; $display("FAIL lat1_drop[%0d] got v=%b d=%h want v=0 d=%h", ra[k], if_a.Valid_out, if_a.Data_out, ea[k]); end
      n_checks++; if (if_b.Valid_out !== 1'b0) begin
        n_fail++; $display("FAIL lat3_early2[%0d] got v=%b want 0", ra[k], if_b.Valid_out); end
      step(1'b0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (if_b.Valid_out !== 1'b1 || if_b.Data_out !== eb[k]) begin
        n_fail++; $display("FAIL wr_rd_b[%0d] got v=%b d=%h want v=1 d=%h", ra[k], if_b.Valid_out, if_b.Data_out, eb[k]); end
      step(1'b0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (if_b.Valid_out !== 1'b0) begin
        n_fail++; $display("FAIL lat3_drop[%0d] got v=%b want 0", ra[k], if_b.Valid_out); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222;
    step(1'b1, 1'b0, 5'd7, 32'h11111111);
    for (int k = 0; k < 2; k++) begin
      // First pass writes the new value on the same edge as the read.
      step(k == 0, 1'b1, 5'd7, 32'h22222222);
      n_checks++; if (if_a.Valid_out !== 1'b1 || if_a.Data_out !== exp_d[k]) begin
        n_fail++; $display("FAIL collide_a[%0d] got v=%b d=%h want v=1 d=%h", k, if_a.Valid_out, if_a.Data_out, exp_d[k]); end
      step(1'b0, 1'b0, 5'd0, 32'h0);
      step(1'b0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (if_b.Valid_out !== 1'b1 || if_b.Data_out !== exp_d[k]) begin
        n_fail++; $display("FAIL collide_b[%0d] got v=%b d=%h want v=1 d=%h", k, if_b.Valid_out, if_b.Data_out, exp_d[k]); end
    end
    step(1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'(i), 32'(i * 16));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i < 8, 5'(i), 32'h0);
      if (i < 8) begin
        n_checks++; if (if_a.Valid_out !== 1'b1 || if_a.Data_out !== 32'(i * 16)) begin
          n_fail++; $display("FAIL stream_a[%0d] got v=%b d=%h want v=1 d=%h", i, if_a.Valid_out, if_a.Data_out, 32'(i * 16)); end
      end
      if (i >= 2) begin
        n_checks++; if (if_b.Valid_out !== 1'b1 || if_b.Data_out !== 32'((i - 2) * 16)) begin
          n_fail++; $display("FAIL stream_b[%0d] got v=%b d=%h want v=1 d=%h", i - 2, if_b.Valid_out, if_b.Data_out, 32'((i - 2) * 16)); end
      end else begin
        n_checks++; if (if_b.Valid_out !== 1'b0) begin
          n_fail++; $display("FAIL stream_b_early[%0d] got v=%b want 0", i, if_b.Valid_out); end
      end
    end
    n_checks++; if (if_a.Valid_out !== 1'b0 || if_a.Data_out !== 32'h70) begin
      n_fail++; $display("FAIL stream_a_hold got v=%b d=%h want v=0 d=00000070", if_a.Valid_out, if_a.Data_out); end
  endtask

  task automatic test_out_of_range();
    logic [4:0]  ra [2];
    logic [31:0] ea [2];
    logic [31:0] eb [2];
    ra[0] = 5'd25; ea[0] = 32'hAAAAAAAA; eb[0] = 32'h0;
    ra[1] = 5'd19; ea[1] = 32'h19191919; eb[1] = 32'h19191919;
    step(1'b1, 1'b0, 5'd19, 32'h19191919);
    step(1'b1, 1'b0, 5'd25, 32'hAAAAAAAA);
    foreach (ra[k]) begin
      step(1'b0, 1'b1, ra[k], 32'h0);
      n_checks++; if (if_a.Valid_out !== 1'b1 || if_a.Data_out !== ea[k]) begin
        n_fail++; $display("FAIL oor_a[%0d] got v=%b d=%h want v=1 d=%h", ra[k], if_a.Valid_out, if_a.Data_out, ea[k]); end
      step(1'b0, 1'b0, 5'd0, 32'h0);
      step(1'b0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (if_b.Valid_out !== 1'b1 || if_b.Data_out !== eb[k]) begin
        n_fail++; $display("FAIL oor_b[%0d] got v=%b d=%h want v=1 d=%h", ra[k], if_b.Valid_out, if_b.Data_out, eb[k]); end
    end
    step(1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b0, 5'd4, 32'h44444444);
    step(1'b0, 1'b1, 5'd4, 32'h0);
    step(1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    n_checks++; if (if_b.Valid_out !== 1'b0 || if_b.Data_out !== 32'h0) begin
      n_fail++; $display("FAIL midrst_b got v=%b d=%h want v=0 d=0", if_b.Valid_out, if_b.Data_out); end
    n_checks++; if (if_a.Data_out !== 32'h0) begin
      n_fail++; $display("FAIL midrst_a_data got %h want 0", if_a.Data_out); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (if_b.Valid_out !== 1'b0) begin
        n_fail++; $display("FAIL midrst_hold_b[%0d] got v=%b want 0", i, if_b.Valid_out); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i == 0, 5'd4, 32'h0);
      if (i == 0) begin
        n_checks++; if (if_a.Valid_out !== 1'b1 || if_a.Data_out !== 32'h0) begin
          n_fail++; $display("FAIL postrst_a got v=%b d=%h want v=1 d=0", if_a.Valid_out, if_a.Data_out); end
      end
      if (i < 2) begin
        n_checks++; if (if_b.Valid_out !== 1'b0) begin
          n_fail++; $display("FAIL postrst_b_early[%0d] got v=%b want 0", i, if_b.Valid_out); end
      end else begin
        n_checks++; if (if_b.Valid_out !== 1'b1 || if_b.Data_out !== 32'h0) begin
          n_fail++; $display("FAIL postrst_b got v=%b d=%h want v=1 d=0", if_b.Valid_out, if_b.Data_out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
